usb_ep2_download_ctrl: RTL and testbench

Host-download front end on the Cypress FX2 synchronous slave-FIFO bus. It reads a host-specified number of 16-bit words from the EP2 OUT FIFO and forwards them on a valid/ready stream to the SDRAM write path. It drives the usb_* slave-FIFO strobes of the simulator top. It absorbs downstream back-pressure through a small internal FIFO and reports completion for download-finished signalling.

---
 rtl/qspi_sim_pkg.sv | 17 +
 rtl/usb_ep2_download_ctrl_if.sv | 28 ++
 rtl/usb_rx_fifo.sv | 43 ++++
 rtl/usb_ep2_download_ctrl.sv | 118 +++++++++++
 tb/tb_usb_ep2_download_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_sim_pkg.sv
// Shared FX2 slave-FIFO constants and the download controller state encoding.
package qspi_sim_pkg;

    localparam logic [1:0] FIFOADR_EP2 = 2'b00;
    localparam logic [1:0] FIFOADR_EP4 = 2'b01;
    localparam logic [1:0] FIFOADR_EP6 = 2'b10;
    localparam logic [1:0] FIFOADR_EP8 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } dl_state_t;

endpackage

// File: rtl/usb_ep2_download_ctrl_if.sv
// FX2 slave-FIFO pins plus the valid/ready word stream toward the SDRAM write path.
interface usb_ep2_download_ctrl_if;
    logic [1:0]  usb_fifoaddr;
    logic        usb_slcs;
    logic        usb_sloe;
    logic        usb_slrd;
    logic        usb_slwr;
    logic        usb_fd_oe;
    logic [15:0] usb_fd_i;
    logic        usb_flagc;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    modport master (
        output usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_fd_oe,
        input  usb_fd_i, usb_flagc,
        output wr_data, wr_valid,
        input  wr_ready
    );

    modport slave (
        input  usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_fd_oe,
        output usb_fd_i, usb_flagc,
        input  wr_data, wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/usb_rx_fifo.sv
// Synchronous FIFO with synchronous flush; head is visible combinationally (zero-latency read).
// Caller must not push when full or pop when empty; flush overrides push and pop.
module usb_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/usb_ep2_download_ctrl.sv
// Reads a counted burst of 16-bit words from FX2 EP2 OUT and streams them downstream.
// One word/cycle; downstream stall fills the local FIFO, then slrd is withheld until space frees.
module usb_ep2_download_ctrl
    import qspi_sim_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter int         CNT_W      = 24,
    parameter logic [1:0] EP_ADDR    = FIFOADR_EP2
) (
    input  logic                 cyp_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     xfer_words,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     words_rcvd,
    usb_ep2_download_ctrl_if.master bus
);
    dl_state_t        state;
    logic [CNT_W-1:0] remaining;
    logic             slcs_q;
    logic             sloe_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic [15:0]      fifo_head;
    logic             rd;
    logic             pop;
    logic             flush;

    // Full is checked before the pop lands, so a pop never makes room for a same-cycle read.
    assign rd    = (state == ST_READ) && bus.usb_flagc && (remaining != '0) && !fifo_full;
    assign pop   = !fifo_empty && bus.wr_ready;
    assign flush = abort && (state != ST_IDLE);

    assign bus.usb_fifoaddr = EP_ADDR;
    assign bus.usb_slcs     = slcs_q;
    assign bus.usb_sloe     = sloe_q;
    assign bus.usb_slrd     = !rd;
    assign bus.usb_slwr     = 1'b1;
    assign bus.usb_fd_oe    = 1'b0;
    assign bus.wr_valid     = !fifo_empty;
    assign bus.wr_data      = fifo_head;

    usb_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk      (cyp_clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (rd),
        .push_dat (bus.usb_fd_i),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge cyp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            words_rcvd <= '0;
            slcs_q     <= 1'b1;
            sloe_q     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state  <= ST_IDLE;
                slcs_q <= 1'b1;
                sloe_q <= 1'b1;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (xfer_words != '0) begin
                                remaining  <= xfer_words;
                                words_rcvd <= '0;
                                busy       <= 1'b1;
                                slcs_q     <= 1'b0;
                                sloe_q     <= 1'b0;
                                state      <= ST_SEL;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_SEL: state <= ST_READ;
                    ST_READ: begin
                        if (rd) begin
                            remaining  <= remaining - CNT_W'(1);
                            words_rcvd <= words_rcvd + CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                slcs_q <= 1'b1;
                                sloe_q <= 1'b1;
                                state  <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (fifo_empty) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_ep2_download_ctrl.sv
// Directed bench: an FX2 source model feeds a scoreboard queue that the output stream is checked against.
module tb_usb_ep2_download_ctrl;
    localparam int CNT_W = 24;

    logic             cyp_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic             start   = 1'b0;
    logic             abort   = 1'b0;
    logic [CNT_W-1:0] xfer_words = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] words_rcvd;

    usb_ep2_download_ctrl_if bus();

    usb_ep2_download_ctrl #(
        .FIFO_DEPTH (8),
        .CNT_W      (CNT_W),
        .EP_ADDR    (2'b00)
    ) dut (
        .cyp_clk    (cyp_clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .xfer_words (xfer_words),
        .busy       (busy),
        .done       (done),
        .words_rcvd (words_rcvd),
        .bus        (bus)
    );

    always #5 cyp_clk = ~cyp_clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] src [$];
    int          src_idx = 0;
    logic [15:0] exp_q [$];
    int          out_cnt = 0;
    int          done_cnt = 0;
    bit          rd_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // FX2 model: a word strobed by slrd at an edge is recorded as expected output, then FD advances.
    always @(negedge cyp_clk) begin
        rd_seen = (bus.usb_slrd === 1'b0);
        if (rd_seen) exp_q.push_back(bus.usb_fd_i);
        if (done === 1'b1) done_cnt++;
        if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
            out_cnt++;
            if (exp_q.size() == 0) chk("unexpected_word", 32'(bus.wr_data), 32'hDEAD);
            else chk("wr_data", 32'(bus.wr_data), 32'(exp_q.pop_front()));
        end
    end

    always @(posedge cyp_clk) begin
        #1;
        if (rd_seen) begin
            src_idx++;
            bus.usb_fd_i = (src_idx < src.size()) ? src[src_idx] : 16'hFFFF;
        end
    end

    task automatic load_src(input int n, input logic [15:0] base, input logic [15:0] step);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(base + 16'(i) * step);
        src_idx = 0;
        bus.usb_fd_i = src[0];
    endtask

    task automatic do_start(input int n);
        @(posedge cyp_clk); #2;
        start = 1'b1; xfer_words = CNT_W'(n);
        @(posedge cyp_clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_idx(input int n, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge cyp_clk); #2;
            if (src_idx >= n) begin got = 1'b1; break; end
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge cyp_clk);
            if (done === 1'b1) begin got = 1'b1; break; end
        end
        chk(tag, 32'(got), 32'd1);
        repeat (4) @(negedge cyp_clk);
    endtask

    int d0, o0;

    initial begin
        bus.usb_flagc = 1'b1;
        bus.wr_ready  = 1'b1;
        bus.usb_fd_i  = 16'h0;
        #12;
        chk("rst_fifoaddr", 32'(bus.usb_fifoaddr), 32'd0);
        chk("rst_slcs", 32'(bus.usb_slcs), 32'd1);
        chk("rst_sloe", 32'(bus.usb_sloe), 32'd1);
        chk("rst_slrd", 32'(bus.usb_slrd), 32'd1);
        chk("rst_slwr", 32'(bus.usb_slwr), 32'd1);
        chk("rst_fd_oe", 32'(bus.usb_fd_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_words", 32'(words_rcvd), 32'd0);
        @(posedge cyp_clk); #2; rst_n = 1'b1;

        // 1: four words, no stalls
        load_src(4, 16'h1111, 16'h1111);
        d0 = done_cnt; o0 = out_cnt;
        do_start(4);
        @(negedge cyp_clk);
        chk("t1_sel_slcs", 32'(bus.usb_slcs), 32'd0);
        chk("t1_sel_sloe", 32'(bus.usb_sloe), 32'd0);
        chk("t1_sel_slrd", 32'(bus.usb_slrd), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge cyp_clk);
            chk("t1_slrd_low", 32'(bus.usb_slrd), 32'd0);
        end
        @(negedge cyp_clk);
        chk("t1_slrd_end", 32'(bus.usb_slrd), 32'd1);
        wait_done("t1_done");
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_words", 32'(words_rcvd), 32'd4);
        chk("t1_out_cnt", 32'(out_cnt - o0), 32'd4);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // 2: empty flag drops for three cycles after word 6
        load_src(16, 16'hA000, 16'h0001);
        o0 = out_cnt;
        do_start(16);
        wait_idx(6, "t2_reach6");
        bus.usb_flagc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge cyp_clk);
            chk("t2_slrd_stall", 32'(bus.usb_slrd), 32'd1);
            @(posedge cyp_clk); #2;
        end
        bus.usb_flagc = 1'b1;
        @(negedge cyp_clk);
        chk("t2_slrd_resume", 32'(bus.usb_slrd), 32'd0);
        wait_done("t2_done");
        chk("t2_words", 32'(words_rcvd), 32'd16);
        chk("t2_out_cnt", 32'(out_cnt - o0), 32'd16);

        // 3: downstream stall fills the FIFO
        load_src(20, 16'h5000, 16'h0101);
        o0 = out_cnt;
        @(posedge cyp_clk); #2; bus.wr_ready = 1'b0;
        do_start(20);
        repeat (15) @(posedge cyp_clk);
        @(negedge cyp_clk);
        chk("t3_idx_full", 32'(src_idx), 32'd8);
        chk("t3_slrd_held", 32'(bus.usb_slrd), 32'd1);
        chk("t3_wr_valid", 32'(bus.wr_valid), 32'd1);
        chk("t3_head", 32'(bus.wr_data), 32'h5000);
        @(posedge cyp_clk); #2; bus.wr_ready = 1'b1;
        wait_done("t3_done");
        chk("t3_words", 32'(words_rcvd), 32'd20);
        chk("t3_out_cnt", 32'(out_cnt - o0), 32'd20);

        // 4: zero-length start
        d0 = done_cnt;
        do_start(0);
        @(negedge cyp_clk);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_slcs", 32'(bus.usb_slcs), 32'd1);
        @(negedge cyp_clk);
        chk("t4_done_drop", 32'(done), 32'd0);
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 5: abort after 5 words
        load_src(16, 16'hC000, 16'h0003);
        do_start(16);
        wait_idx(5, "t5_reach5");
        bus.usb_flagc = 1'b0;
        abort = 1'b1;
        d0 = done_cnt;
        @(posedge cyp_clk); #2;
        abort = 1'b0;
        exp_q.delete();
        @(negedge cyp_clk);
        chk("t5_slcs", 32'(bus.usb_slcs), 32'd1);
        chk("t5_sloe", 32'(bus.usb_sloe), 32'd1);
        chk("t5_slrd", 32'(bus.usb_slrd), 32'd1);
        chk("t5_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_words", 32'(words_rcvd), 32'd5);
        repeat (6) @(negedge cyp_clk);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        bus.usb_flagc = 1'b1;

        // 6: asynchronous reset mid-read
        load_src(16, 16'h7000, 16'h0010);
        do_start(16);
        wait_idx(5, "t6_reach5");
        #1; rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_slcs", 32'(bus.usb_slcs), 32'd1);
        chk("t6_sloe", 32'(bus.usb_sloe), 32'd1);
        chk("t6_slrd", 32'(bus.usb_slrd), 32'd1);
        chk("t6_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_words", 32'(words_rcvd), 32'd0);
        repeat (2) @(posedge cyp_clk);
        #2; rst_n = 1'b1;
        load_src(4, 16'h0BEE, 16'h0002);
        o0 = out_cnt;
        do_start(4);
        wait_done("t6_restart_done");
        chk("t6_restart_words", 32'(words_rcvd), 32'd4);
        chk("t6_restart_out", 32'(out_cnt - o0), 32'd4);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
